// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter with a registered one-hot grant that is held while the owner keeps requesting.
// Optional hold timeout: define ARB_HOLD_TIMEOUT_EN to force rotation after MAX_HOLD cycles when others wait.
module rr_priority_arbiter #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld,
  output logic             zero
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg;
  logic [N-1:0]     grant_reg;
  logic [IDX_W-1:0] grant_idx_reg;
  logic [IDX_W-1:0] last_reg;
  logic             grant_vld_reg;

  logic [N-1:0]     search_req;
  logic [N-1:0]     win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             win_found;
  logic             owner_req;
  logic             hold_expired;
  logic             take;
  logic             release_grant;

  if (N < 2 || IDX_W != $clog2(N) || MAX_HOLD < 1) begin : g_param_check
    $error("rr_priority_arbiter: illegal parameter combination");
  end

  // The current owner is never a candidate while BUSY: either it dropped, or it is being rotated out.
  assign search_req = (state_reg == BUSY) ? (req & ~grant_reg) : req;

  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((32'(last_reg) + 32'(i)) % 32'(N));
      if (!win_found && search_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_win_onehot
    assign win_onehot[gi] = win_found && (win_idx == IDX_W'(gi));
  end

  assign owner_req     = req[grant_idx_reg];
  assign take          = win_found && ((state_reg == IDLE) || !owner_req || hold_expired);
  assign release_grant = (state_reg == BUSY) && !owner_req && !win_found;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] hold_cnt_reg;

  assign hold_expired = (state_reg == BUSY) && (hold_cnt_reg == CNT_W'(MAX_HOLD));

  // Counts cycles of the current grant; saturates when nobody else is waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_reg <= '0;
    end else if (take) begin
      hold_cnt_reg <= CNT_W'(1);
    end else if (state_reg == BUSY && hold_cnt_reg != CNT_W'(MAX_HOLD)) begin
      hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      grant_idx_reg <= '0;
      grant_vld_reg <= 1'b0;
      last_reg      <= IDX_W'(N - 1);
    end else if (take) begin
      state_reg     <= BUSY;
      grant_reg     <= win_onehot;
      grant_idx_reg <= win_idx;
      grant_vld_reg <= 1'b1;
      last_reg      <= win_idx;
    end else if (release_grant) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      grant_idx_reg <= '0;
      grant_vld_reg <= 1'b0;
    end
  end

  assign grant     = grant_reg;
  assign grant_idx = grant_idx_reg;
  assign grant_vld = grant_vld_reg;
  assign zero      = ~|req;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed and randomized checks of rr_priority_arbiter against a queue-based round-robin model.
module tb_rr_priority_arbiter;
  localparam int N        = 4;
  localparam int IDX_W    = 2;
  localparam int MAX_HOLD = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld;
  logic             zero;

  int total = 0;
  int bad   = 0;

  // Reference model: owner (-1 = none), last granted index, cycles of current grant.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_cnt   = 0;

  rr_priority_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant), .grant_idx(grant_idx), .grant_vld(grant_vld), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requesters in round-robin order after m_last, excluding one index; first one wins.
  function automatic int pick(input logic [N-1:0] r, input int excl);
    int order[$];
    for (int k = 1; k <= N; k++) order.push_back((m_last + k) % N);
    foreach (order[k]) if (r[order[k]] && order[k] != excl) return order[k];
    return -1;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic rn);
    int w;
    if (!rn) begin
      m_owner = -1; m_last = N - 1; m_cnt = 0;
    end else if (m_owner < 0 || !r[m_owner]) begin
      w = pick(r, m_owner);
      if (w >= 0) begin m_owner = w; m_last = w; m_cnt = 1; end
      else begin m_owner = -1; m_cnt = 0; end
    end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
      if (m_cnt >= MAX_HOLD) begin
        w = pick(r, m_owner);
        if (w >= 0) begin m_owner = w; m_last = w; m_cnt = 1; end
      end else begin
        m_cnt++;
      end
`endif
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic rn);
    logic [N-1:0] exp_grant;
    req = r; rst_n = rn;
    #1;
    chk("zero", {31'd0, zero}, {31'd0, (r == '0)});
    @(posedge clk);
    model_edge(r, rn);
    #1;
    exp_grant = (m_owner < 0) ? '0 : N'(1) << m_owner;
    chk("grant", 32'(grant), 32'(exp_grant));
    chk("grant_idx", 32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk("grant_vld", {31'd0, grant_vld}, {31'd0, (m_owner >= 0)});
    chk("onehot", 32'($countones(grant) <= 1), 32'd1);
    $display("step rst_n=%0b req=%b grant=%b idx=%0d vld=%0b", rn, r, grant, grant_idx, grant_vld);
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] exp_hold;

    // Reset with all requests high: nothing granted, zero low.
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    chk("t1_reset_grant", 32'(grant), 32'd0);
    step(4'b1111, 1'b1);
    chk("t1_first_grant", 32'(grant), 32'b0001);

    // Rotation with no bubble as each owner drops for one cycle.
    step(4'b1110, 1'b1); chk("t2_g1", 32'(grant), 32'b0010);
    step(4'b1101, 1'b1); chk("t2_g2", 32'(grant), 32'b0100);
    step(4'b1011, 1'b1); chk("t2_g3", 32'(grant), 32'b1000);
    step(4'b0111, 1'b1); chk("t2_g0", 32'(grant), 32'b0001);

    // Wrap and skip: owner 2 releases with only 0 and 1 requesting.
    step(4'b0100, 1'b1); chk("t3_own2", 32'(grant), 32'b0100);
    step(4'b0011, 1'b1); chk("t3_wrap", 32'(grant), 32'b0001);

    // All requests drop.
    step(4'b0000, 1'b1);
    chk("t5_idle_grant", 32'(grant), 32'd0);
    chk("t5_idle_vld", {31'd0, grant_vld}, 32'd0);

    // Owner 1 holds for 20 cycles while 2 waits.
    step(4'b0110, 1'b1); chk("t4_start", 32'(grant), 32'b0010);
    for (int k = 1; k < 20; k++) begin
      step(4'b0110, 1'b1);
`ifdef ARB_HOLD_TIMEOUT_EN
      exp_hold = (((k / MAX_HOLD) % 2) == 0) ? 4'b0010 : 4'b0100;
`else
      exp_hold = 4'b0010;
`endif
      chk("t4_hold", 32'(grant), 32'(exp_hold));
    end

    // Mid-grant reset; search restarts at 0.
    step(4'b1000, 1'b1); chk("t6_own3", 32'(grant), 32'b1000);
    step(4'b1000, 1'b0); chk("t6_reset", 32'(grant), 32'd0);
    step(4'b1000, 1'b1); chk("t6_regrant", 32'(grant), 32'b1000);

    // Randomized sticky requests with occasional reset.
    r = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      step(r, ($urandom_range(0, 63) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
